prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the data/address width of the stream and the memory bus.
REQ-002 SHALL have port clk, input, 1 bit; the single clock, with all state updating on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit; a one-cycle pulse that begins a load session.
REQ-005 SHALL have port in_valid, input, 1 bit; the stream word on in_data is valid.
REQ-006 SHALL have port in_data, input, WIDTH bits; the stream word.
REQ-007 SHALL have port in_ready, output, 1 bit; the loader accepts a word this cycle.
REQ-008 SHALL have port MI, output, 1 bit; memory address-register load strobe.
REQ-009 SHALL have port RI, output, 1 bit; memory write strobe, writing ram[mar].
REQ-010 SHALL have port write, output, WIDTH bits; the memory write/address bus.
REQ-011 SHALL have port cpu_hold, output, 1 bit; high keeps the processor in reset.
REQ-012 SHALL have port done, output, 1 bit; high when the program is loaded and the processor is released.
REQ-013 SHALL have port error, output, 1 bit; high when the session was aborted (checksum build only).

Function
REQ-014 SHALL accept a stream word on each rising edge where in_valid=1 and in_ready=1.
REQ-015 SHALL interpret the stream, in order, as: ORG (first load address), CNT (word count), CNT data words, then SUM (CHECKSUM_EN builds only).
REQ-016 SHALL implement these FSM states: IDLE, GET_ORG, GET_CNT, GET_DATA, SET_MAR, WR_DATA, VEC_MAR, VEC_WR, GET_SUM, DONE, ERROR.
REQ-017 SHALL assert in_ready only in GET_ORG, GET_CNT, GET_DATA and GET_SUM, and drive it low in all other states.
REQ-018 SHALL move IDLE/DONE/ERROR -> GET_ORG on start=1, clearing done and error and setting cpu_hold=1; start SHALL be ignored in all other states.
REQ-019 SHALL, on an accepted word, move GET_ORG -> GET_CNT latching addr=ORG, and GET_CNT -> GET_DATA latching cnt=CNT; when CNT=0 it SHALL go to VEC_MAR, or to GET_SUM if CHECKSUM_EN is defined.
REQ-020 SHALL move GET_DATA -> SET_MAR when a data word is accepted, latching that word.
REQ-021 SHALL, in SET_MAR, drive MI=1 and write=addr for exactly one cycle.
REQ-022 SHALL, in WR_DATA, drive RI=1 and write=data for exactly one cycle.
REQ-023 SHALL, on leaving WR_DATA, set addr=addr+1 and cnt=cnt-1; if the new cnt is nonzero it SHALL return to GET_DATA, otherwise go to VEC_MAR (or GET_SUM).
REQ-024 SHALL, in VEC_MAR, drive MI=1 with write=0.
REQ-025 SHALL, in VEC_WR, drive RI=1 with write=ORG-1, so the processor fetches its first instruction from ORG; it then goes to DONE.
REQ-026 SHALL, in DONE, hold done=1 and cpu_hold=0 until the next start.
REQ-027 SHALL drive MI=0, RI=0 and write=0 in every state not listed in REQ-021, REQ-022, REQ-024 and REQ-025; MI and RI SHALL never both be high.
REQ-028 SHALL compute all address, count and checksum arithmetic modulo 2^WIDTH; addr wraps from 2^WIDTH-1 to 0.
REQ-029 SHALL take a minimum of 3 cycles per data word, and SHALL NOT lose or duplicate words under any in_valid stall pattern.
REQ-030 SHALL keep cpu_hold=1 in every state except DONE.

Reset
REQ-031 SHALL, when reset=1 at a rising edge, go to IDLE with addr=0, cnt=0, MI=0, RI=0, write=0, in_ready=0, done=0, error=0 and cpu_hold=1, regardless of the current state.
REQ-032 SHALL, on reset mid-session, abandon the session with no further memory strobes; memory already written is left as it is.

Configuration
REQ-033 SHALL, with macro PROG_LOADER_CHECKSUM_EN defined, accumulate sum=ORG+CNT+all data words (mod 2^WIDTH) and accept a SUM word in GET_SUM.
REQ-034 SHALL, with PROG_LOADER_CHECKSUM_EN defined, go from GET_SUM to VEC_MAR when SUM equals the accumulated sum, and otherwise to ERROR, setting error=1, keeping cpu_hold=1 and not writing the vector.
REQ-035 SHALL, without PROG_LOADER_CHECKSUM_EN, omit GET_SUM and ERROR entirely, tie error to 0, and make the stream end after the last data word.

Verification
REQ-036 SHALL be verified (WIDTH=8, no checksum) with: start; stream 100, 3, 0x41, 0x0C, 0xFF with in_valid always high -> memory writes ram[100]=0x41, ram[101]=0x0C, ram[102]=0xFF and ram[0]=99; done=1 and cpu_hold=0 exactly 2 cycles after the final RI.
REQ-037 SHALL be verified with: in_valid toggled pseudo-randomly over the stream of REQ-036 -> identical memory contents, and exactly 4 RI pulses and 4 MI pulses.
REQ-038 SHALL be verified with: stream 254, 3, 1, 2, 3 -> writes ram[254]=1, ram[255]=2, ram[0]=3, then the vector overwrites ram[0]=253.
REQ-039 SHALL be verified with: stream 50, 0 -> no data writes, ram[0]=49, done=1.
REQ-040 SHALL be verified with: reset asserted while in WR_DATA of the second word -> next cycle IDLE, MI=RI=0, cpu_hold=1, done=0; start is then accepted normally.
REQ-041 SHALL be verified (checksum build) with: stream 100, 1, 5, SUM=106 -> done=1; the same stream with SUM=107 -> error=1, cpu_hold=1, ram[0] unchanged.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: loads a program stream (ORG, CNT, CNT data words[, SUM]) into RAM via MI/RI strobes, then writes the start vector.
// Latency: at least 3 cycles per data word; done/cpu_hold change one registered cycle after the DONE state is entered.
// Backpressure: in_ready is high only in the GET_* states. Define PROG_LOADER_CHECKSUM_EN to enable SUM checking.

module prog_loader #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             MI,
  output logic             RI,
  output logic [WIDTH-1:0] write,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    GET_ORG  = 4'd1,
    GET_CNT  = 4'd2,
    GET_DATA = 4'd3,
    SET_MAR  = 4'd4,
    WR_DATA  = 4'd5,
    VEC_MAR  = 4'd6,
    VEC_WR   = 4'd7,
    DONE     = 4'd8
`ifdef PROG_LOADER_CHECKSUM_EN
    ,
    GET_SUM  = 4'd9,
    ERROR    = 4'd10
`endif
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Where the FSM goes once the last data word (or a zero count) has been handled.
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = GET_SUM;
`else
  localparam state_t AFTER_DATA = VEC_MAR;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;   // next RAM address to write
  logic [WIDTH-1:0] cnt_q, cnt_d;     // data words still to be written
  logic [WIDTH-1:0] org_q, org_d;     // first load address, needed for the vector
  logic [WIDTH-1:0] data_q, data_d;   // data word waiting to be written
  logic             done_q, done_d;
  logic [WIDTH-1:0] cnt_dec;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] sum_q, sum_d;     // running ORG + CNT + data sum
  logic             error_q, error_d;
`endif

  assign cnt_dec = cnt_q - ONE;

  // Next-state, datapath updates and decoded memory-bus outputs.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    org_d    = org_q;
    data_d   = data_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    in_ready = 1'b0;
    MI       = 1'b0;
    RI       = 1'b0;
    write    = '0;

    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = GET_ORG;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ERROR: begin
        if (start) state_d = GET_ORG;
      end
`endif
      GET_ORG: begin
        in_ready = 1'b1;
        if (in_valid) begin
          addr_d  = in_data;
          org_d   = in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d   = in_data;
`endif
          state_d = GET_CNT;
        end
      end
      GET_CNT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_d   = in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d   = sum_q + in_data;
`endif
          state_d = (in_data == '0) ? AFTER_DATA : GET_DATA;
        end
      end
      GET_DATA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d   = sum_q + in_data;
`endif
          state_d = SET_MAR;
        end
      end
      SET_MAR: begin
        MI      = 1'b1;
        write   = addr_q;
        state_d = WR_DATA;
      end
      WR_DATA: begin
        RI      = 1'b1;
        write   = data_q;
        addr_d  = addr_q + ONE;
        cnt_d   = cnt_dec;
        state_d = (cnt_dec != '0) ? GET_DATA : AFTER_DATA;
      end
      VEC_MAR: begin
        MI      = 1'b1;
        write   = '0;
        state_d = VEC_WR;
      end
      VEC_WR: begin
        // The processor increments its PC before the first fetch, so store ORG-1.
        RI      = 1'b1;
        write   = org_q - ONE;
        state_d = DONE;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      GET_SUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = (in_data == sum_q) ? VEC_MAR : ERROR;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status flags are registered off the current state; a start pulse clears them on the same edge the session restarts.
  always_comb begin
    done_d  = (state_q == DONE) && !start;
`ifdef PROG_LOADER_CHECKSUM_EN
    error_d = (state_q == ERROR) && !start;
`endif
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      org_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q   <= '0;
      error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      org_q   <= org_d;
      data_q  <= data_d;
      done_q  <= done_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      error_q <= error_d;
`endif
    end
  end

  assign done     = done_q;
  assign cpu_hold = ~done_q;

`ifdef PROG_LOADER_CHECKSUM_EN
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: drives randomized program streams into prog_loader (WIDTH=8) and checks a RAM image against a reference.
// Latency: checks done/cpu_hold timing relative to the final RI strobe.
// Backpressure: in_valid is toggled pseudo-randomly; start noise is injected mid-session.

module tb_prog_loader;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         MI;
  logic         RI;
  logic [W-1:0] write;
  logic         cpu_hold;
  logic         done;
  logic         error;

  int checks   = 0;
  int failures = 0;

  prog_loader #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .MI       (MI),
    .RI       (RI),
    .write    (write),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  // Memory attached to the loader's strobes, plus strobe statistics.
  logic [7:0] ram [256];
  logic [7:0] mar;
  int mi_cnt, ri_cnt, both_cnt, cyc, last_ri_cyc;

  initial begin : memory_monitor
    for (int i = 0; i < 256; i++) ram[i] = 8'(i * 7 + 3);
    mar = 8'h00; mi_cnt = 0; ri_cnt = 0; both_cnt = 0; cyc = 0; last_ri_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (MI && RI) both_cnt++;
      if (MI === 1'b1) begin mar = write; mi_cnt++; end
      if (RI === 1'b1) begin ram[mar] = write; ri_cnt++; last_ri_cyc = cyc; end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Session description and expected memory image.
  logic [7:0] s_org, s_cnt;
  logic [7:0] s_data[$];
  bit         s_bad;
  logic [7:0] stream_q[$];
  logic [7:0] exp_ram [256];
  bit         drv_abort;

  task automatic build_stream();
    stream_q = {};
    stream_q.push_back(s_org);
    stream_q.push_back(s_cnt);
    foreach (s_data[i]) stream_q.push_back(s_data[i]);
`ifdef PROG_LOADER_CHECKSUM_EN
    begin
      logic [7:0] sum;
      sum = s_org + s_cnt;
      foreach (s_data[i]) sum = sum + s_data[i];
      stream_q.push_back(sum + 8'(s_bad));
    end
`endif
  endtask

  // Reference: data words land at consecutive addresses from ORG (mod 256); a good session then stores ORG-1 at 0.
  task automatic model(input logic [7:0] snap [256], input int nwr, input bit vec);
    exp_ram = snap;
    for (int i = 0; i < nwr; i++) exp_ram[8'(s_org + 8'(i))] = s_data[i];
    if (vec) exp_ram[0] = s_org - 8'd1;
  endtask

  task automatic begin_session();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive_stream(input bit rnd, input bit noise, output bit ok);
    int idx = 0;
    int guard = 0;
    while (idx < stream_q.size() && guard < 3000 && !drv_abort) begin
      @(negedge clk);
      guard++;
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? stream_q[idx] : 8'($urandom);
      start    = noise && ($urandom_range(0, 3) == 0);
      #1;
      if (in_valid && in_ready) idx++;
    end
    ok = (idx == stream_q.size());
    @(negedge clk);
    in_valid = 1'b0; start = 1'b0;
  endtask

  task automatic check_ram(input string name);
    int bad = -1;
    for (int a = 0; a < 256; a++) if (ram[a] !== exp_ram[a] && bad < 0) bad = a;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s ram[%0d]: got %0h expected %0h", name, bad, ram[bad], exp_ram[bad]);
    end
  endtask

  task automatic run_session(input string name, input bit rnd, input bit noise);
    logic [7:0] snap [256];
    bit ok, vec;
    int mi0, ri0, t, done_cyc;
    snap = ram; mi0 = mi_cnt; ri0 = ri_cnt;
    vec = !s_bad;
    build_stream();
    begin_session();
    drive_stream(rnd, noise, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL %s accept: stream of %0d words not fully accepted", name, stream_q.size()); end
    t = 0;
    while (t < 200 && !(done || error)) begin @(negedge clk); #1; t++; end
    done_cyc = cyc;
    checks++;
    if (done !== vec) begin failures++; $display("FAIL %s done: got %b expected %b", name, done, vec); end
    checks++;
    if (error !== !vec) begin failures++; $display("FAIL %s error: got %b expected %b", name, error, !vec); end
    checks++;
    if (cpu_hold !== !vec) begin failures++; $display("FAIL %s cpu_hold: got %b expected %b", name, cpu_hold, !vec); end
    if (vec) begin
      checks++;
      if (done_cyc - last_ri_cyc != 2) begin
        failures++; $display("FAIL %s done_latency: got %0d cycles after last RI expected 2", name, done_cyc - last_ri_cyc);
      end
    end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (mi_cnt - mi0 != int'(s_cnt) + int'(vec)) begin
      failures++; $display("FAIL %s mi_pulses: got %0d expected %0d", name, mi_cnt - mi0, int'(s_cnt) + int'(vec));
    end
    checks++;
    if (ri_cnt - ri0 != int'(s_cnt) + int'(vec)) begin
      failures++; $display("FAIL %s ri_pulses: got %0d expected %0d", name, ri_cnt - ri0, int'(s_cnt) + int'(vec));
    end
    model(snap, int'(s_cnt), vec);
    check_ram(name);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; drv_abort = 1'b0; s_bad = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset in_ready: got %b expected 0", in_ready); end
    checks++; if (MI !== 1'b0)       begin failures++; $display("FAIL reset MI: got %b expected 0", MI); end
    checks++; if (RI !== 1'b0)       begin failures++; $display("FAIL reset RI: got %b expected 0", RI); end
    checks++; if (write !== 8'h00)   begin failures++; $display("FAIL reset write: got %0h expected 0", write); end
    checks++; if (done !== 1'b0)     begin failures++; $display("FAIL reset done: got %b expected 0", done); end
    checks++; if (error !== 1'b0)    begin failures++; $display("FAIL reset error: got %b expected 0", error); end
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL reset cpu_hold: got %b expected 1", cpu_hold); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    s_org = 8'd100; s_cnt = 8'd3; s_data = {8'h41, 8'h0C, 8'hFF}; s_bad = 1'b0;
    run_session("basic", 1'b0, 1'b0);
    checks++; if (ram[100] !== 8'h41) begin failures++; $display("FAIL basic ram100: got %0h expected 41", ram[100]); end
    checks++; if (ram[101] !== 8'h0C) begin failures++; $display("FAIL basic ram101: got %0h expected 0c", ram[101]); end
    checks++; if (ram[102] !== 8'hFF) begin failures++; $display("FAIL basic ram102: got %0h expected ff", ram[102]); end
    checks++; if (ram[0] !== 8'd99)   begin failures++; $display("FAIL basic vector: got %0d expected 99", ram[0]); end
  endtask

  task automatic test_stall();
    s_org = 8'd100; s_cnt = 8'd3; s_data = {8'h41, 8'h0C, 8'hFF}; s_bad = 1'b0;
    run_session("stall", 1'b1, 1'b1);
  endtask

  task automatic test_wrap();
    s_org = 8'd254; s_cnt = 8'd3; s_data = {8'd1, 8'd2, 8'd3}; s_bad = 1'b0;
    run_session("wrap", 1'b1, 1'b0);
    checks++; if (ram[254] !== 8'd1) begin failures++; $display("FAIL wrap ram254: got %0d expected 1", ram[254]); end
    checks++; if (ram[255] !== 8'd2) begin failures++; $display("FAIL wrap ram255: got %0d expected 2", ram[255]); end
    checks++; if (ram[0] !== 8'd253) begin failures++; $display("FAIL wrap vector: got %0d expected 253", ram[0]); end
  endtask

  task automatic test_zero_cnt();
    s_org = 8'd50; s_cnt = 8'd0; s_data = {}; s_bad = 1'b0;
    run_session("zero_cnt", 1'b0, 1'b0);
    checks++; if (ram[0] !== 8'd49) begin failures++; $display("FAIL zero_cnt vector: got %0d expected 49", ram[0]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      s_org = 8'($urandom); s_cnt = 8'($urandom_range(0, 5)); s_bad = 1'b0;
      s_data = {};
      for (int i = 0; i < int'(s_cnt); i++) s_data.push_back(8'($urandom));
      run_session("random", 1'b1, 1'b1);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] snap [256];
    bit ok;
    int mi0, ri0, t;
    s_org = 8'($urandom); s_cnt = 8'd4; s_bad = 1'b0;
    s_data = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    snap = ram; mi0 = mi_cnt; ri0 = ri_cnt; t = 0;
    build_stream();
    begin_session();
    drv_abort = 1'b0;
    fork
      drive_stream(1'b0, 1'b0, ok);
      begin
        while (ri_cnt - ri0 < 2 && t < 100) begin @(negedge clk); #1; t++; end
        reset = 1'b1; drv_abort = 1'b1;
      end
    join
    #1;
    checks++; if (t >= 100)          begin failures++; $display("FAIL mid_reset reach_wr: second data write not seen"); end
    checks++; if (MI !== 1'b0)       begin failures++; $display("FAIL mid_reset MI: got %b expected 0", MI); end
    checks++; if (RI !== 1'b0)       begin failures++; $display("FAIL mid_reset RI: got %b expected 0", RI); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_reset in_ready: got %b expected 0", in_ready); end
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL mid_reset cpu_hold: got %b expected 1", cpu_hold); end
    checks++; if (done !== 1'b0)     begin failures++; $display("FAIL mid_reset done: got %b expected 0", done); end
    @(negedge clk);
    reset = 1'b0; drv_abort = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (mi_cnt - mi0 != 2 || ri_cnt - ri0 != 2) begin
      failures++; $display("FAIL mid_reset strobes: got MI=%0d RI=%0d expected 2 and 2", mi_cnt - mi0, ri_cnt - ri0);
    end
    model(snap, 2, 1'b0);
    check_ram("mid_reset");
    s_org = 8'($urandom); s_cnt = 8'd2; s_data = {8'($urandom), 8'($urandom)};
    run_session("after_reset", 1'b1, 1'b0);
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    s_org = 8'd100; s_cnt = 8'd1; s_data = {8'd5}; s_bad = 1'b0;
    run_session("sum_good", 1'b0, 1'b0);
    s_bad = 1'b1;
    run_session("sum_bad", 1'b0, 1'b0);
    s_bad = 1'b0;
    s_org = 8'($urandom); s_cnt = 8'd3; s_data = {8'($urandom), 8'($urandom), 8'($urandom)};
    run_session("sum_random", 1'b1, 1'b1);
  endtask
`endif

  task automatic test_exclusive();
    checks++;
    if (both_cnt != 0) begin failures++; $display("FAIL strobe_exclusive: MI and RI high together in %0d cycles, expected 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_zero_cnt();
    test_random();
    test_mid_reset();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
